mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXE_TO_MEM_BUS_WD, default 75, width of the incoming EXE bus.
REQ-002 SHALL have parameter MEM_TO_WB_BUS_WD, default 104, width of the outgoing WB bus.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction.
- EXE_to_MEM_bus  in  75  [74:43] PC_plus_4, [42:11] alu_res, [10:6] rf waddr, [5:4] sel_rf_w_data, [3] rf_w_en, [2:0] ld_op.
- MEM_allow_in  out  1  MEM accepts this cycle.
- data_sram_data_ok  in  1  one-cycle load-data return pulse.
- data_sram_rdata  in  32  load data, valid with data_ok.
- WB_allow_in  in  1  WB accepts this cycle.
- MEM_to_WB_valid  out  1  MEM offers an instruction.
- MEM_to_WB_bus  out  104  [103:72] PC_plus_4, [71:40] alu_res, [39:8] load data, [7:3] waddr, [2:1] sel, [0] wen.
- MEM_fwd_bus  out  39  [38] valid, [37] data_ready, [36:32] waddr, [31:0] data, for ID forwarding/interlock.

Function
REQ-005 ld_op encoding SHALL be: 0 none, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU; codes 6 and 7 SHALL be treated as none.
REQ-006 MEM_allow_in SHALL equal ~MEM_valid | (MEM_ready_go & WB_allow_in).
- MEM_valid loads EXE_to_MEM_valid when MEM_allow_in is high.
- The bus register captures only on EXE_to_MEM_valid & MEM_allow_in.
REQ-007 The FSM SHALL have states EMPTY, WAIT_DATA, READY.
- Accepting a load enters WAIT_DATA.
- Accepting a non-load enters READY.
- When nothing is accepted and the current instruction leaves, the FSM goes to EMPTY.
REQ-008 In WAIT_DATA, data_sram_data_ok SHALL capture rdata into a 32-bit hold register and move to READY in the next cycle.
- Any data_ok outside WAIT_DATA is ignored.
REQ-009 MEM_ready_go SHALL be 1 only in READY, giving minimum latency:
- 1 cycle for non-loads;
- data_ok cycle + 1 for loads.
REQ-010 MEM_to_WB_valid SHALL equal MEM_valid & MEM_ready_go.
REQ-011 While READY and WB_allow_in is low, all outputs SHALL hold stable and the hold register SHALL not change.
REQ-012 Load data SHALL be aligned using alu_res[1:0]:
- LB/LBU select byte alu_res[1:0], then sign-/zero-extend.
- LH/LHU select halfword alu_res[1], then sign-/zero-extend; alu_res[0] is ignored.
- LW passes the data through.
- Non-loads drive 0.
REQ-013 A departure and a new acceptance in the same cycle SHALL proceed back-to-back with no bubble (READY->READY or READY->WAIT_DATA).
REQ-014 MEM_fwd_bus valid SHALL be MEM_valid & rf_w_en & (waddr != 0).
- data_ready SHALL be 0 in WAIT_DATA.
- data SHALL be the aligned load data for loads, PC_plus_4+4 when sel=01, and alu_res otherwise.

Reset
REQ-015 Reset SHALL asynchronously force:
- FSM to EMPTY, MEM_valid = 0, MEM_to_WB_valid = 0, MEM_allow_in = 1, fwd valid = 0;
- the bus register and hold register to 0.
REQ-016 Reset asserted mid-load SHALL abandon the load, and a data_ok arriving after reset release SHALL be ignored.

Structure
REQ-017 A shared package/header SHALL define:
- bus width constants EXE_TO_MEM_BUS_WD, MEM_TO_WB_BUS_WD, MEM_FWD_BUS_WD;
- the ld_op codes;
- the sel_rf_w_data codes.
REQ-018 One sub-module, load_align (combinational: ld_op, addr[1:0], rdata -> 32-bit result), SHALL implement REQ-012.

Verification
REQ-019 ALU op: alu_res=0x1234, waddr=5, wen=1 -> MEM_to_WB_valid the next cycle with bus[71:40]=0x1234 and [7:3]=5; fwd data_ready=1.
REQ-020 LB load: addr low bits=2'b11, data_ok after 3 cycles with rdata=0x80FF_FF7F -> load data 0xFFFF_FF80, valid the cycle after data_ok; MEM_allow_in=0 while waiting.
REQ-021 LHU load: addr[1]=1, rdata=0x9ABC_0000 -> 0x0000_9ABC; LH with the same inputs -> 0xFFFF_9ABC.
REQ-022 WB_allow_in held at 0 for 4 cycles in READY -> outputs stable and EXE stalled; an ALU op following a load streams with no bubble once WB_allow_in=1.
REQ-023 Reset pulsed in WAIT_DATA, then data_ok -> no MEM_to_WB_valid and FSM stays EMPTY.
REQ-024 Stray data_ok in EMPTY or READY -> no change to the hold register or the outputs.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, load opcodes,
// register-file write-source selects and the stage FSM encoding.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WD = 75;
  localparam int MEM_TO_WB_BUS_WD  = 104;
  localparam int MEM_FWD_BUS_WD    = 39;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LW   = 3'd1;
  localparam logic [2:0] LD_LB   = 3'd2;
  localparam logic [2:0] LD_LBU  = 3'd3;
  localparam logic [2:0] LD_LH   = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_PC8  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_DATA = 2'd1,
    READY     = 2'd2
  } mem_state_e;

  // Codes 6 and 7 are reserved and behave like a non-load.
  function automatic logic is_load(input logic [2:0] op);
    return (op >= LD_LW) && (op <= LD_LHU);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[addr];
  // Halfword loads ignore addr[0]; misalignment is not trapped here.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = '0;
    case (ld_op)
      LD_LW:   result = rdata;
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      LD_NONE: result = '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data when needed,
// and hands the formatted result to WB while exporting a forwarding view to ID.
module mem_stage #(
  parameter int EXE_TO_MEM_BUS_WD = mem_stage_pkg::EXE_TO_MEM_BUS_WD,
  parameter int MEM_TO_WB_BUS_WD  = mem_stage_pkg::MEM_TO_WB_BUS_WD
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     EXE_to_MEM_valid,
  input  logic [EXE_TO_MEM_BUS_WD-1:0]             EXE_to_MEM_bus,
  output logic                                     MEM_allow_in,
  input  logic                                     data_sram_data_ok,
  input  logic [31:0]                              data_sram_rdata,
  input  logic                                     WB_allow_in,
  output logic                                     MEM_to_WB_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]              MEM_to_WB_bus,
  output logic [mem_stage_pkg::MEM_FWD_BUS_WD-1:0] MEM_fwd_bus
);
  import mem_stage_pkg::*;

  mem_state_e                   state_reg, state_next;
  logic                         mem_valid_reg;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_reg;
  logic [31:0]                  hold_reg;

  logic        mem_ready_go;
  logic        accept;
  logic        leave;
  logic [31:0] pc_plus_4;
  logic [31:0] alu_res;
  logic [4:0]  waddr;
  logic [1:0]  sel;
  logic        wen;
  logic [2:0]  ld_op;
  logic [31:0] load_data;
  logic [31:0] fwd_data;

  assign pc_plus_4 = bus_reg[74:43];
  assign alu_res   = bus_reg[42:11];
  assign waddr     = bus_reg[10:6];
  assign sel       = bus_reg[5:4];
  assign wen       = bus_reg[3];
  assign ld_op     = bus_reg[2:0];

  assign mem_ready_go    = (state_reg == READY);
  assign MEM_allow_in    = ~mem_valid_reg | (mem_ready_go & WB_allow_in);
  assign accept          = EXE_to_MEM_valid & MEM_allow_in;
  assign leave           = mem_valid_reg & mem_ready_go & WB_allow_in;
  assign MEM_to_WB_valid = mem_valid_reg & mem_ready_go;

  // A new acceptance wins over a departure so back-to-back traffic has no bubble.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = is_load(EXE_to_MEM_bus[2:0]) ? WAIT_DATA : READY;
    end else if (leave) begin
      state_next = EMPTY;
    end else if ((state_reg == WAIT_DATA) && data_sram_data_ok) begin
      state_next = READY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_reg <= 1'b0;
      bus_reg       <= '0;
      hold_reg      <= '0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid_reg <= EXE_to_MEM_valid;
      end
      if (accept) begin
        bus_reg <= EXE_to_MEM_bus;
      end
      // Only a return for the outstanding load is captured; strays are dropped.
      if ((state_reg == WAIT_DATA) && data_sram_data_ok) begin
        hold_reg <= data_sram_rdata;
      end
    end
  end

  load_align u_load_align (
    .ld_op  (ld_op),
    .addr   (alu_res[1:0]),
    .rdata  (hold_reg),
    .result (load_data)
  );

  always_comb begin
    fwd_data = alu_res;
    if (is_load(ld_op)) begin
      fwd_data = load_data;
    end else if (sel == SEL_PC8) begin
      fwd_data = pc_plus_4 + 32'd4;
    end
  end

  assign MEM_to_WB_bus = {pc_plus_4, alu_res, load_data, waddr, sel, wen};
  assign MEM_fwd_bus   = {mem_valid_reg & wen & (waddr != 5'd0),
                          state_reg != WAIT_DATA,
                          waddr,
                          fwd_data};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB buses are queued at EXE handshake
// and compared when WB takes them; directed checks cover stalls and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk;
  logic         reset;
  logic         EXE_to_MEM_valid;
  logic [74:0]  EXE_to_MEM_bus;
  logic         MEM_allow_in;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         WB_allow_in;
  logic         MEM_to_WB_valid;
  logic [103:0] MEM_to_WB_bus;
  logic [38:0]  MEM_fwd_bus;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [103:0] sb_q[$];
  logic [31:0]  plan_rdata;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .EXE_to_MEM_bus    (EXE_to_MEM_bus),
    .MEM_allow_in      (MEM_allow_in),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allow_in       (WB_allow_in),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .MEM_fwd_bus       (MEM_fwd_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [74:0] mk_exe(input logic [31:0] pc4, input logic [31:0] alu,
                                         input logic [4:0] wa, input logic [1:0] sel,
                                         input logic wen, input logic [2:0] op);
    return {pc4, alu, wa, sel, wen, op};
  endfunction

  function automatic logic [31:0] align_model(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = d >> (int'(a) * 8);
    sh = d >> (a[1] ? 16 : 0);
    case (op)
      3'd1:    return d;
      3'd2:    return {{24{sb[7]}}, sb[7:0]};
      3'd3:    return {24'd0, sb[7:0]};
      3'd4:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [103:0] exp_wb(input logic [74:0] exe, input logic [31:0] rd);
    return {exe[74:43], exe[42:11], align_model(exe[2:0], exe[12:11], rd),
            exe[10:6], exe[5:4], exe[3]};
  endfunction

  function automatic logic [38:0] exp_fwd(input logic [74:0] exe, input logic [31:0] rd,
                                          input logic rdy);
    logic [31:0] d;
    if (exe[2:0] >= 3'd1 && exe[2:0] <= 3'd5) d = align_model(exe[2:0], exe[12:11], rd);
    else if (exe[5:4] == 2'b01)                d = exe[74:43] + 32'd4;
    else                                        d = exe[42:11];
    return {exe[3] && (exe[10:6] != 5'd0), rdy, exe[10:6], d};
  endfunction

  // Scoreboard: pop on WB handshake, then push on EXE handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (MEM_to_WB_valid && WB_allow_in) begin
        if (sb_q.size() == 0) check_val("wb_unexpected", {103'd0, MEM_to_WB_valid}, 104'd0);
        else                  check_val("wb_bus", MEM_to_WB_bus, sb_q.pop_front());
      end
      if (EXE_to_MEM_valid && MEM_allow_in) sb_q.push_back(exp_wb(EXE_to_MEM_bus, plan_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [74:0] exe, input logic [31:0] rd);
    plan_rdata       = rd;
    EXE_to_MEM_bus   = exe;
    EXE_to_MEM_valid = 1'b1;
    @(negedge clk);
    check_val("issue_allow_in", MEM_allow_in, 1);
    tick();
    EXE_to_MEM_valid = 1'b0;
  endtask

  task automatic return_data(input int delay, input logic [31:0] rd, input logic fwd_v);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_val("wait_allow_in", MEM_allow_in, 0);
      check_val("wait_wb_valid", MEM_to_WB_valid, 0);
      check_val("wait_fwd_ready", MEM_fwd_bus[37], 0);
      check_val("wait_fwd_valid", MEM_fwd_bus[38], fwd_v);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(negedge clk);
    check_val("dataok_wb_valid", MEM_to_WB_valid, 0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
  endtask

  task automatic do_alu(input logic [74:0] exe);
    issue(exe, 32'h0);
    @(negedge clk);
    check_val("alu_wb_valid", MEM_to_WB_valid, 1);
    check_val("alu_fwd", MEM_fwd_bus, exp_fwd(exe, 32'h0, 1'b1));
    tick();
  endtask

  task automatic do_load(input logic [74:0] exe, input logic [31:0] rd, input int delay);
    issue(exe, rd);
    return_data(delay, rd, exe[3] && (exe[10:6] != 5'd0));
    @(negedge clk);
    check_val("load_wb_valid", MEM_to_WB_valid, 1);
    check_val("load_fwd", MEM_fwd_bus, exp_fwd(exe, rd, 1'b1));
    tick();
  endtask

  initial begin
    logic [74:0]  exe_a, exe_b, exe_c, exe_d;
    logic [31:0]  rd_a, rd_c;
    logic [103:0] last_wb;

    reset             = 1'b1;
    EXE_to_MEM_valid  = 1'b0;
    EXE_to_MEM_bus    = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    WB_allow_in       = 1'b1;
    plan_rdata        = '0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_allow_in", MEM_allow_in, 1);
    check_val("rst_wb_valid", MEM_to_WB_valid, 0);
    check_val("rst_fwd_valid", MEM_fwd_bus[38], 0);
    check_val("rst_wb_bus", MEM_to_WB_bus, 104'd0);
    reset = 1'b0;
    tick();

    // Plain ALU result, one-cycle latency.
    do_alu(mk_exe(32'h100, 32'h1234, 5'd5, SEL_ALU, 1'b1, LD_NONE));
    @(negedge clk);
    check_val("alu_departed", MEM_to_WB_valid, 0);
    check_val("alu_res_field", MEM_to_WB_bus[71:40], 32'h1234);
    check_val("alu_waddr_field", MEM_to_WB_bus[7:3], 5);
    tick();

    do_alu(mk_exe(32'h200, 32'hABCD, 5'd31, SEL_PC8, 1'b1, LD_NONE));
    do_alu(mk_exe(32'h300, 32'h5555, 5'd0, SEL_ALU, 1'b1, LD_NONE));
    do_alu(mk_exe(32'h304, 32'h7777, 5'd3, SEL_ALU, 1'b1, 3'd6));

    // Byte, halfword and word loads with varying return delays.
    do_load(mk_exe(32'h400, 32'h2003, 5'd7, SEL_LOAD, 1'b1, LD_LB), 32'h80FF_FF7F, 3);
    @(negedge clk);
    check_val("lb_data", MEM_to_WB_bus[39:8], 32'hFFFF_FF80);
    tick();
    do_load(mk_exe(32'h404, 32'h3002, 5'd8, SEL_LOAD, 1'b1, LD_LHU), 32'h9ABC_0000, 1);
    @(negedge clk);
    check_val("lhu_data", MEM_to_WB_bus[39:8], 32'h0000_9ABC);
    tick();
    do_load(mk_exe(32'h408, 32'h3003, 5'd8, SEL_LOAD, 1'b1, LD_LH), 32'h9ABC_0000, 2);
    @(negedge clk);
    check_val("lh_data", MEM_to_WB_bus[39:8], 32'hFFFF_9ABC);
    tick();
    do_load(mk_exe(32'h40C, 32'h4001, 5'd9, SEL_LOAD, 1'b1, LD_LBU), 32'h1122_F344, 0);
    exe_a = mk_exe(32'h410, 32'h4000, 5'd0, SEL_LOAD, 1'b1, LD_LW);
    do_load(exe_a, 32'hCAFE_F00D, 1);
    last_wb = exp_wb(exe_a, 32'hCAFE_F00D);

    // Stray data_ok while empty must not disturb the held result.
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check_val("stray_empty_valid", MEM_to_WB_valid, 0);
    check_val("stray_empty_bus", MEM_to_WB_bus, last_wb);
    tick();

    // Load stalled by WB with an ALU op queued behind it, then load streaming in.
    exe_a = mk_exe(32'h500, 32'h6000, 5'd9, SEL_LOAD, 1'b1, LD_LW);
    rd_a  = 32'h0BAD_F00D;
    exe_b = mk_exe(32'h504, 32'h0042, 5'd10, SEL_ALU, 1'b1, LD_NONE);
    exe_c = mk_exe(32'h508, 32'h6006, 5'd11, SEL_LOAD, 1'b1, LD_LBU);
    rd_c  = 32'h00A5_0000;
    issue(exe_a, rd_a);
    EXE_to_MEM_bus   = exe_b;
    EXE_to_MEM_valid = 1'b1;
    return_data(1, rd_a, 1'b1);
    WB_allow_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("stall_wb_valid", MEM_to_WB_valid, 1);
      check_val("stall_allow_in", MEM_allow_in, 0);
      check_val("stall_bus", MEM_to_WB_bus, exp_wb(exe_a, rd_a));
      check_val("stall_fwd", MEM_fwd_bus, exp_fwd(exe_a, rd_a, 1'b1));
      tick();
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = 32'h5555_5555;
    end
    data_sram_data_ok = 1'b0;
    WB_allow_in       = 1'b1;
    @(negedge clk);
    check_val("release_allow_in", MEM_allow_in, 1);
    tick();
    plan_rdata       = rd_c;
    EXE_to_MEM_bus   = exe_c;
    @(negedge clk);
    check_val("stream_no_bubble", MEM_to_WB_valid, 1);
    check_val("stream_alu_fwd", MEM_fwd_bus, exp_fwd(exe_b, 32'h0, 1'b1));
    tick();
    EXE_to_MEM_valid = 1'b0;
    return_data(2, rd_c, 1'b1);
    @(negedge clk);
    check_val("stream_load_valid", MEM_to_WB_valid, 1);
    tick();

    // Reset during an outstanding load; the late data_ok must be ignored.
    exe_d = mk_exe(32'h600, 32'h7000, 5'd12, SEL_LOAD, 1'b1, LD_LW);
    issue(exe_d, 32'h1111_2222);
    @(negedge clk);
    check_val("pre_rst_wait", MEM_fwd_bus[37], 0);
    tick();
    reset = 1'b1;
    #1;
    check_val("async_rst_allow_in", MEM_allow_in, 1);
    check_val("async_rst_fwd_ready", MEM_fwd_bus[37], 1);
    #1;
    reset = 1'b0;
    sb_q.delete();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    tick();
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst_wb_valid", MEM_to_WB_valid, 0);
      check_val("post_rst_allow_in", MEM_allow_in, 1);
      check_val("post_rst_fwd_valid", MEM_fwd_bus[38], 0);
      check_val("post_rst_bus", MEM_to_WB_bus, 104'd0);
      tick();
    end

    check_val("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
